// File: rtl/camera_sccb_config.sv
// Power-up SCCB configuration sequencer: walks an external {reg,val} table and
// issues one 3-phase SCCB write per entry, with DELAY and END sentinels.
module camera_sccb_config #(
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned SCCB_HZ   = 100_000,
    parameter logic [7:0]  DEV_ADDR  = 8'h42,
    parameter int unsigned ROM_AW    = 8,
    parameter int unsigned DELAY_CYC = 250_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_scl,
    output logic              sccb_sda_oe,
    output logic              busy,
    output logic              done
);
    localparam int unsigned QTR = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned DW  = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYC - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, BYTE, STOP, GAP, DELAY, FIN} state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic [1:0]        qidx_q, qidx_d;
    logic [3:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic [7:0]        reg_q, reg_d, val_q, val_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              scl_q, scl_d, sda_oe_q, sda_oe_d;
    logic              qtick, advance;
    logic [7:0]        cur_byte;
    logic              cur_bit;

    assign qtick = (qcnt_q == QTR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            fetch_ph_q <= 1'b0;
            qcnt_q     <= '0;
            qidx_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            dly_q      <= '0;
            reg_q      <= '0;
            val_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            fetch_ph_q <= fetch_ph_d;
            qcnt_q     <= qcnt_d;
            qidx_q     <= qidx_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            dly_q      <= dly_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        fetch_ph_d = fetch_ph_q;
        qcnt_d     = '0;
        qidx_d     = qidx_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        dly_d      = dly_q;
        reg_d      = reg_q;
        val_d      = val_q;
        busy_d     = busy_q;
        done_d     = done_q;
        advance    = 1'b0;

        if (state_q inside {START, BYTE, STOP, GAP})
            qcnt_d = qtick ? '0 : qcnt_q + 1'b1;

        unique case (state_q)
            IDLE: if (start) begin
                busy_d     = 1'b1;
                done_d     = 1'b0;
                rom_addr_d = '0;
                fetch_ph_d = 1'b0;
                state_d    = FETCH;
            end
            FETCH: begin
                fetch_ph_d = ~fetch_ph_q;
                if (fetch_ph_q) begin
                    if (rom_data == 16'hFFFF) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (rom_data == 16'hFFF0) begin
                        state_d = DELAY;
                        dly_d   = '0;
                    end else begin
                        reg_d   = rom_data[15:8];
                        val_d   = rom_data[7:0];
                        qidx_d  = '0;
                        state_d = START;
                    end
                end
            end
            START: if (qtick) begin
                qidx_d = qidx_q + 2'd1;
                if (qidx_q == 2'd1) begin
                    qidx_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = BYTE;
                end
            end
            BYTE: if (qtick) begin
                qidx_d = qidx_q + 2'd1;
                if (qidx_q == 2'd3) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        bit_d = '0;
                        if (byte_q == 2'd2) state_d = STOP;
                        else                byte_d  = byte_q + 2'd1;
                    end
                end
            end
            STOP: if (qtick) begin
                qidx_d = qidx_q + 2'd1;
                if (qidx_q == 2'd2) begin
                    qidx_d  = '0;
                    state_d = GAP;
                end
            end
            GAP:   advance = qtick && (qidx_q == 2'd3);
            DELAY: begin
                dly_d   = dly_q + 1'b1;
                advance = (dly_q == DLY_LAST);
            end
            FIN:   state_d = IDLE;
        endcase

        if (state_q == GAP && qtick) qidx_d = qidx_q + 2'd1;

        // The last table slot ends the run even without a sentinel; the address wraps to 0.
        if (advance) begin
            rom_addr_d = rom_addr_q + 1'b1;
            fetch_ph_d = 1'b0;
            if (&rom_addr_q) begin
                state_d = FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        unique case (byte_q)
            2'd1:    cur_byte = reg_q;
            2'd2:    cur_byte = val_q;
            default: cur_byte = DEV_ADDR;
        endcase
        cur_bit = (bit_q < 4'd8) ? cur_byte[3'd7 - bit_q[2:0]] : 1'b1;

        unique case (state_q)
            START: sda_oe_d = (qidx_q == 2'd1);
            BYTE: begin
                scl_d    = (qidx_q == 2'd1) || (qidx_q == 2'd2);
                sda_oe_d = ~cur_bit;
            end
            STOP: begin
                scl_d    = (qidx_q != 2'd0);
                sda_oe_d = (qidx_q != 2'd2);
            end
            default: ;
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign sccb_scl    = scl_q;
    assign sccb_sda_oe = sda_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_camera_sccb_config.sv
// Directed bench for camera_sccb_config: a 4-entry registered ROM model and an
// SCCB bus monitor that decodes frames and checks START/STOP and SCL period.
module tb_camera_sccb_config;
    localparam int QTR = 10;       // 4 MHz / (4 * 100 kHz)
    localparam int DLY = 300;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sccb_scl;
    logic        sccb_sda_oe;
    logic        busy;
    logic        done;

    logic [15:0] rom [4];

    int n_vec = 0;
    int n_bad = 0;

    camera_sccb_config #(
        .CLK_HZ   (4_000_000),
        .SCCB_HZ  (100_000),
        .DEV_ADDR (8'h42),
        .ROM_AW   (2),
        .DELAY_CYC(DLY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_scl   (sccb_scl),
        .sccb_sda_oe(sccb_sda_oe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Bus monitor, sampled on the falling clock edge.
    logic        sda_line;
    assign sda_line = ~sccb_sda_oe;
    logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0, in_frame = 1'b0;
    logic [23:0] frame_sr = '0;
    logic [23:0] frames [16];
    int mon_cyc = 0, last_rise = 0, nbits = 0, frame_cnt = 0;
    int starts = 0, stops = 0, bad_period = 0, done_rises = 0;

    always @(negedge clk) begin
        mon_cyc   <= mon_cyc + 1;
        prev_scl  <= sccb_scl;
        prev_sda  <= sda_line;
        prev_done <= done;
        if (done && !prev_done) done_rises <= done_rises + 1;
        if (sccb_scl && prev_scl && prev_sda && !sda_line) begin
            starts   <= starts + 1;
            in_frame <= 1'b1;
            nbits    <= 0;
            frame_sr <= '0;
        end else if (sccb_scl && prev_scl && !prev_sda && sda_line) begin
            stops    <= stops + 1;
            in_frame <= 1'b0;
            if (in_frame && nbits == 27 && frame_cnt < 16) begin
                frames[frame_cnt] <= frame_sr;
                frame_cnt         <= frame_cnt + 1;
            end
        end else if (sccb_scl && !prev_scl && in_frame) begin
            if (nbits > 0 && (mon_cyc - last_rise) != 4 * QTR) bad_period <= bad_period + 1;
            last_rise <= mon_cyc;
            if (nbits < 27) begin
                if (nbits % 9 != 8) frame_sr <= {frame_sr[22:0], sda_line};
                nbits <= nbits + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] e0, e1, e2, e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    // Pulse start, then count cycles until done (or stop_at / limit). Extra start
    // pulses are driven at cycles p1 and p2. Ends one cycle later so monitor counters settle.
    task automatic run_seq(input int p1, input int p2, input int stop_at, input int limit,
                           output int cyc, output int sda_cyc, output logic busy_prev,
                           output logic busy_end);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc       = 0;
        sda_cyc   = -1;
        busy_prev = busy;
        busy_end  = busy;
        while (!done && cyc < limit && cyc != stop_at) begin
            busy_prev = busy;
            @(negedge clk);
            cyc++;
            start = (cyc == p1) || (cyc == p2);
            if (sccb_sda_oe && sda_cyc < 0) sda_cyc = cyc;
        end
        start    = 1'b0;
        busy_end = busy;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc, sda_cyc, base, b_st, b_sp, b_bp, b_dr;
        logic        bprev, bend;
        logic [15:0] t6 [4];

        reset_n = 1'b0;
        start   = 1'b0;
        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_scl", sccb_scl, 1);
        check("rst_sda_oe", sccb_sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write 42/12/80: 117*QTR bus cycles plus two 2-cycle fetches.
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = frame_cnt;
        run_seq(-1, -1, -1, 6000, cyc, sda_cyc, bprev, bend);
        check("t1_done_cycle", cyc, 1174);
        check("t1_busy_before", bprev, 1);
        check("t1_busy_at_done", bend, 0);
        check("t1_done", done, 1);
        check("t1_rom_addr", rom_addr, 1);
        check("t1_frames", frame_cnt - base, 1);
        check("t1_frame", frames[base], 24'h421280);

        // DELAY entry first: START falls SDA at DLY + 2 fetches*2 + QTR + 1 output register.
        load(16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF);
        base = frame_cnt;
        run_seq(-1, -1, -1, 6000, cyc, sda_cyc, bprev, bend);
        check("t2_first_sda_low", sda_cyc, DLY + QTR + 5);
        check("t2_done_cycle", cyc, DLY + 117 * QTR + 6);
        check("t2_frames", frame_cnt - base, 1);
        check("t2_frame", frames[base], 24'h421100);

        // Reset in the middle of the first data bit (SCL high, SDA low), then rerun.
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = frame_cnt;
        run_seq(-1, -1, 40, 6000, cyc, sda_cyc, bprev, bend);
        check("t3_busy_mid", busy, 1);
        check("t3_scl_mid", sccb_scl, 1);
        check("t3_sda_oe_mid", sccb_sda_oe, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t3_rst_scl", sccb_scl, 1);
        check("t3_rst_sda_oe", sccb_sda_oe, 0);
        check("t3_rst_busy", busy, 0);
        check("t3_rst_done", done, 0);
        check("t3_rst_rom_addr", rom_addr, 0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("t3_no_partial_frame", frame_cnt - base, 0);
        run_seq(-1, -1, -1, 6000, cyc, sda_cyc, bprev, bend);
        check("t3_rerun_cycle", cyc, 1174);
        check("t3_rerun_frames", frame_cnt - base, 1);
        check("t3_rerun_frame", frames[base], 24'h421280);

        // Two writes with start pulses landing mid-run; they must change nothing.
        load(16'hAB5A, 16'h3C0F, 16'hFFFF, 16'hFFFF);
        base = frame_cnt;
        b_dr = done_rises;
        run_seq(500, 1500, -1, 6000, cyc, sda_cyc, bprev, bend);
        check("t4_done_cycle", cyc, 2 * (117 * QTR + 2) + 2);
        check("t4_frames", frame_cnt - base, 2);
        check("t4_frame0", frames[base], 24'h42AB5A);
        check("t4_frame1", frames[base + 1], 24'h423C0F);
        check("t4_done_rises", done_rises - b_dr, 1);

        // Three writes under the bus monitor.
        load(16'h0A55, 16'h3CC3, 16'h7E01, 16'hFFFF);
        base = frame_cnt;
        b_st = starts;
        b_sp = stops;
        b_bp = bad_period;
        run_seq(-1, -1, -1, 8000, cyc, sda_cyc, bprev, bend);
        check("t5_done_cycle", cyc, 3 * (117 * QTR + 2) + 2);
        check("t5_frames", frame_cnt - base, 3);
        check("t5_frame0", frames[base], 24'h420A55);
        check("t5_frame1", frames[base + 1], 24'h423CC3);
        check("t5_frame2", frames[base + 2], 24'h427E01);
        check("t5_starts", starts - b_st, 3);
        check("t5_stops", stops - b_sp, 3);
        check("t5_bad_scl_period", bad_period - b_bp, 0);

        // Full table with no sentinel: four writes, then wrap ends the run.
        t6[0] = 16'h0102; t6[1] = 16'h0304; t6[2] = 16'h0506; t6[3] = 16'h0708;
        load(t6[0], t6[1], t6[2], t6[3]);
        base = frame_cnt;
        run_seq(-1, -1, -1, 8000, cyc, sda_cyc, bprev, bend);
        check("t6_done_cycle", cyc, 4 * (117 * QTR + 2));
        check("t6_frames", frame_cnt - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_frame%0d", i), frames[base + i], {8'h42, t6[i]});
        check("t6_done", done, 1);
        check("t6_busy", busy, 0);
        check("t6_rom_addr", rom_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
